workout_sequencer: RTL and testbench

Parametrised successor to the single-plan workout FSM. It runs a programmable number of timed exercises with an optional rest interval between them, and divides the board clock into one-second ticks internally. It also produces a stretched buzzer pulse at every phase change. It sits between the time calculator (`T_input`) and the LCD/buzzer drivers: `workout_num` feeds the exercise-name decoder, and `time_remain` feeds the LCD controller.

---
 rtl/workout_sequencer.sv | 175 +++++++++++++++++
 tb/tb_workout_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/workout_sequencer.sv
// workout_sequencer
//   Runs N_EX timed exercises separated by optional rest intervals, derives
//   one-second ticks from the board clock and emits a stretched buzzer pulse
//   on every phase entry (including entry into DONE).
//
//   Optional feature macro: WORKOUT_PAUSE_EN (adds pause input / paused output).
//
//   Ports
//     clk          in   board clock, rising edge
//     reset        in   asynchronous, active-low
//     start        in   level; begins a session from IDLE or DONE
//     skip         in   pulse; ends the current WORK/REST phase
//     T_input      in   exercise length in seconds, latched at start
//     workout_num  out  current exercise index
//     time_remain  out  seconds left in the current phase
//     phase        out  0 IDLE, 1 WORK, 2 REST, 3 DONE
//     buzzer       out  buzzer level
//     done         out  high in DONE
//     pause/paused      only with WORKOUT_PAUSE_EN
//
//   state   | meaning
//   S_IDLE  | after reset, waiting for start
//   S_WORK  | exercise countdown running
//   S_REST  | rest countdown between exercises
//   S_DONE  | session finished, waiting for start
module workout_sequencer #(
  parameter int N_EX     = 8,
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int REST_SEC = 10,
  parameter int BUZZ_CYC = 25_000_000,
  localparam int NUM_W   = (N_EX > 1) ? $clog2(N_EX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip,
  input  logic [7:0]        T_input,
`ifdef WORKOUT_PAUSE_EN
  input  logic              pause,
  output logic              paused,
`endif
  output logic [NUM_W-1:0]  workout_num,
  output logic [TIME_W-1:0] time_remain,
  output logic [1:0]        phase,
  output logic              buzzer,
  output logic              done
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BUZ_W = $clog2(BUZZ_CYC + 1);
  localparam logic [TIME_W-1:0] T_MAX = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WORK = 2'd1, S_REST = 2'd2, S_DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [TIME_W-1:0] tr_q, tr_d;
  logic [TIME_W-1:0] tlat_q, tlat_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [BUZ_W-1:0]  buz_q, buz_d;
  logic              buzzer_q;
  logic              run, hold, tick, entry;
  logic [TIME_W-1:0] t_clamp;

  assign run  = (state_q == S_WORK) || (state_q == S_REST);
  assign tick = run && (pre_q == PRE_W'(TICK_DIV - 1));

`ifdef WORKOUT_PAUSE_EN
  logic paused_q;
  assign hold   = pause && run;
  assign paused = paused_q;
`else
  assign hold = 1'b0;
`endif

  // T_input is 8 bits wide regardless of TIME_W, so clamp in 32-bit space.
  always_comb begin
    t_clamp = TIME_W'(T_input);
    if (T_input == 8'd0)
      t_clamp = TIME_W'(1);
    else if (32'(T_input) > 32'(T_MAX))
      t_clamp = T_MAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      tr_q     <= '0;
      tlat_q   <= '0;
      pre_q    <= '0;
      buz_q    <= '0;
      buzzer_q <= 1'b0;
`ifdef WORKOUT_PAUSE_EN
      paused_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      tr_q     <= tr_d;
      tlat_q   <= tlat_d;
      pre_q    <= pre_d;
      buz_q    <= buz_d;
      buzzer_q <= (buz_d != '0);
`ifdef WORKOUT_PAUSE_EN
      paused_q <= hold;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    tr_d    = tr_q;
    tlat_d  = tlat_q;
    entry   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WORK;
          num_d   = '0;
          tlat_d  = t_clamp;
          tr_d    = t_clamp;
          entry   = 1'b1;
        end
      end
      default: begin
        if (!hold) begin
          // skip and a terminal tick in the same cycle produce a single advance
          if (skip || (tick && tr_q <= TIME_W'(1))) begin
            entry = 1'b1;
            if (state_q == S_WORK && num_q == NUM_W'(N_EX - 1)) begin
              state_d = S_DONE;
              tr_d    = '0;
            end else if (state_q == S_WORK && REST_SEC > 0) begin
              state_d = S_REST;
              tr_d    = TIME_W'(REST_SEC);
            end else begin
              state_d = S_WORK;
              num_d   = num_q + NUM_W'(1);
              tr_d    = tlat_q;
            end
          end else if (tick) begin
            tr_d = tr_q - TIME_W'(1);
          end
        end
      end
    endcase

    if (entry)
      pre_d = '0;
    else if (run && !hold)
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    else
      pre_d = pre_q;

    // buzzer counter runs independently of pause and phase
    if (entry)
      buz_d = BUZ_W'(BUZZ_CYC);
    else if (buz_q != '0)
      buz_d = buz_q - BUZ_W'(1);
    else
      buz_d = '0;
  end

  always_comb begin
    phase       = state_q;
    done        = (state_q == S_DONE);
    workout_num = num_q;
    time_remain = tr_q;
    buzzer      = buzzer_q;
  end

endmodule

// File: tb/tb_workout_sequencer.sv
module tb_workout_sequencer;

  localparam int TD  = 4;
  localparam int NEX = 3;
  localparam int BZ  = 2;
`ifdef WORKOUT_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       skip = 1'b0;
  logic [7:0] T_input = 8'd3;

  logic [1:0] ph_a, ph_b, num_a, num_b;
  logic [7:0] tr_a, tr_b;
  logic       bz_a, bz_b, dn_a, dn_b, pd_a, pd_b;
  logic [14:0] out_a, out_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef WORKOUT_PAUSE_EN
  logic pause_r = 1'b0;
`else
  assign pd_a = 1'b0;
  assign pd_b = 1'b0;
`endif

  workout_sequencer #(.N_EX(NEX), .TIME_W(8), .TICK_DIV(TD), .REST_SEC(2), .BUZZ_CYC(BZ)) dut_a (
    .clk(clk), .reset(reset), .start(start), .skip(skip), .T_input(T_input),
`ifdef WORKOUT_PAUSE_EN
    .pause(pause_r), .paused(pd_a),
`endif
    .workout_num(num_a), .time_remain(tr_a), .phase(ph_a), .buzzer(bz_a), .done(dn_a));

  workout_sequencer #(.N_EX(NEX), .TIME_W(8), .TICK_DIV(TD), .REST_SEC(0), .BUZZ_CYC(BZ)) dut_b (
    .clk(clk), .reset(reset), .start(start), .skip(skip), .T_input(T_input),
`ifdef WORKOUT_PAUSE_EN
    .pause(pause_r), .paused(pd_b),
`endif
    .workout_num(num_b), .time_remain(tr_b), .phase(ph_b), .buzzer(bz_b), .done(dn_b));

  assign out_a = {ph_a, num_a, tr_a, bz_a, dn_a, pd_a};
  assign out_b = {ph_b, num_b, tr_b, bz_b, dn_b, pd_b};

  // Reference model: tracks cycles elapsed since phase entry and since the
  // last buzzer trigger; remaining seconds are derived by division.
  typedef struct {
    int ph, idx, len, el, tl, since;
    bit paused;
  } mdl_t;

  mdl_t m_a, m_b;

  function automatic mdl_t mreset();
    mdl_t r;
    r.ph = 0; r.idx = 0; r.len = 0; r.el = 0; r.tl = 0; r.since = 1000; r.paused = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int rest, bit st, bit sk, int t, bit pz);
    mdl_t n = m;
    bit entered = 1'b0;
    bit run = (m.ph == 1) || (m.ph == 2);
    bit frz = pz && PAUSE_EN && run;
    n.paused = frz;
    if (!run) begin
      if (st) begin
        n.tl = (t == 0) ? 1 : t;
        n.ph = 1; n.idx = 0; n.len = n.tl; entered = 1'b1;
      end
    end else if (!frz) begin
      if (sk || (m.el + 1 == m.len * TD)) begin
        entered = 1'b1;
        if (m.ph == 1 && m.idx == NEX - 1) begin
          n.ph = 3; n.len = 0;
        end else if (m.ph == 1 && rest > 0) begin
          n.ph = 2; n.len = rest;
        end else begin
          n.ph = 1; n.idx = m.idx + 1; n.len = m.tl;
        end
      end else begin
        n.el = m.el + 1;
      end
    end
    if (entered) begin
      n.el = 0; n.since = 0;
    end else if (m.since < 1000) begin
      n.since = m.since + 1;
    end
    return n;
  endfunction

  function automatic logic [14:0] mpack(mdl_t m);
    int tr = m.len - m.el / TD;
    return {2'(m.ph), 2'(m.idx), 8'(tr), (m.since < BZ), (m.ph == 3), m.paused};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=0x%0h want=0x%0h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp_all(string nm);
    chk({nm, "_rest2"}, 32'(out_a), 32'(mpack(m_a)));
    chk({nm, "_rest0"}, 32'(out_b), 32'(mpack(m_b)));
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, compare.
  task automatic step(input bit st, input bit sk, input logic [7:0] t, input bit pz);
    start = st; skip = sk; T_input = t;
`ifdef WORKOUT_PAUSE_EN
    pause_r = pz;
`endif
    @(posedge clk);
    m_a = mstep(m_a, 2, st, sk, int'(t), pz);
    m_b = mstep(m_b, 0, st, sk, int'(t), pz);
    @(negedge clk);
    cmp_all("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; skip = 1'b0;
`ifdef WORKOUT_PAUSE_EN
    pause_r = 1'b0;
`endif
    #1;
    m_a = mreset(); m_b = mreset();
    cmp_all("reset_async");
    @(posedge clk);
    @(negedge clk);
    cmp_all("reset_hold");
    reset = 1'b1;
  endtask

  typedef struct {
    bit st, sk;
    logic [7:0] t;
    logic [1:0] ph, num;
    logic [7:0] tr;
    bit bz, dn;
  } vec_t;

  function automatic vec_t mk(bit st, bit sk, int t, int ph, int num, int tr, bit bz, bit dn);
    vec_t v;
    v.st = st; v.sk = sk; v.t = 8'(t); v.ph = 2'(ph); v.num = 2'(num); v.tr = 8'(tr);
    v.bz = bz; v.dn = dn;
    return v;
  endfunction

  vec_t tbl[30];

  initial begin
    int done_at, pulses, cnt;
    bit prev_bz;

    tbl[0]  = mk(1,0,3, 1,0,3,1,0);
    tbl[1]  = mk(0,0,3, 1,0,3,1,0);
    tbl[2]  = mk(0,0,3, 1,0,3,0,0);
    tbl[3]  = mk(0,0,3, 1,0,3,0,0);
    tbl[4]  = mk(0,0,3, 1,0,2,0,0);
    tbl[5]  = mk(0,0,3, 1,0,2,0,0);
    tbl[6]  = mk(0,0,3, 1,0,2,0,0);
    tbl[7]  = mk(0,0,3, 1,0,2,0,0);
    tbl[8]  = mk(0,0,3, 1,0,1,0,0);
    tbl[9]  = mk(0,0,3, 1,0,1,0,0);
    tbl[10] = mk(0,0,3, 1,0,1,0,0);
    tbl[11] = mk(0,0,3, 1,0,1,0,0);
    tbl[12] = mk(0,1,3, 2,0,2,1,0);
    tbl[13] = mk(0,0,3, 2,0,2,1,0);
    tbl[14] = mk(0,0,3, 2,0,2,0,0);
    tbl[15] = mk(0,0,3, 2,0,2,0,0);
    tbl[16] = mk(0,0,3, 2,0,1,0,0);
    tbl[17] = mk(0,1,3, 1,1,3,1,0);
    tbl[18] = mk(1,0,5, 1,1,3,1,0);
    tbl[19] = mk(0,0,5, 1,1,3,0,0);
    tbl[20] = mk(0,1,5, 2,1,2,1,0);
    tbl[21] = mk(0,1,5, 1,2,3,1,0);
    tbl[22] = mk(0,1,5, 3,2,0,1,1);
    tbl[23] = mk(0,1,5, 3,2,0,1,1);
    tbl[24] = mk(0,0,5, 3,2,0,0,1);
    tbl[25] = mk(1,0,0, 1,0,1,1,0);
    tbl[26] = mk(0,0,0, 1,0,1,1,0);
    tbl[27] = mk(0,0,0, 1,0,1,0,0);
    tbl[28] = mk(0,0,0, 1,0,1,0,0);
    tbl[29] = mk(0,0,0, 2,0,2,1,0);

    m_a = mreset(); m_b = mreset();
    do_reset();
    chk("reset_zero", 32'({ph_a, num_a, tr_a, bz_a, dn_a}), 32'd0);

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].st, tbl[i].sk, tbl[i].t, 1'b0);
      chk($sformatf("vec%0d", i), 32'({ph_a, num_a, tr_a, bz_a, dn_a}),
          32'({tbl[i].ph, tbl[i].num, tbl[i].tr, tbl[i].bz, tbl[i].dn}));
    end

    // Full session without skip: DONE 52 cycles after start.
    do_reset();
    step(1'b1, 1'b0, 8'd3, 1'b0);
    done_at = -1; pulses = 0; prev_bz = bz_a;
    for (int n = 1; n <= 100; n++) begin
      step(1'b0, 1'b0, 8'd3, 1'b0);
      if (dn_a) begin
        done_at = n;
        break;
      end
      if (bz_a && !prev_bz) pulses++;
      prev_bz = bz_a;
    end
    chk("done_cycle", 32'(done_at), 32'd52);
    chk("buzz_pulses", 32'(pulses), 32'd4);
    chk("done_num", 32'(num_a), 32'd2);
    chk("done_buzz", 32'(bz_a), 32'd1);

    // Reset in the middle of REST.
    do_reset();
    step(1'b1, 1'b0, 8'd3, 1'b0);
    for (int n = 0; n < 14; n++) step(1'b0, 1'b0, 8'd3, 1'b0);
    chk("mid_rest_phase", 32'(ph_a), 32'd2);
    do_reset();
    step(1'b1, 1'b0, 8'd4, 1'b0);
    chk("restart", 32'({ph_a, num_a, tr_a}), 32'({2'd1, 2'd0, 8'd4}));

    // No-rest instance goes WORK0 -> WORK1 directly.
    do_reset();
    step(1'b1, 1'b0, 8'd1, 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 8'd1, 1'b0);
    chk("norest_work1", 32'({ph_b, num_b, tr_b}), 32'({2'd1, 2'd1, 8'd1}));
    chk("rest_entered", 32'({ph_a, num_a, tr_a}), 32'({2'd2, 2'd0, 8'd2}));

`ifdef WORKOUT_PAUSE_EN
    do_reset();
    step(1'b1, 1'b0, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd3, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 8'd3, 1'b0);
    for (int n = 0; n < 10; n++) step(1'b0, (n == 3), 8'd3, 1'b1);
    chk("pause_hold", 32'({ph_a, num_a, tr_a, pd_a}), 32'({2'd1, 2'd1, 8'd2, 1'b1}));
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step(1'b0, 1'b0, 8'd3, 1'b0);
      cnt++;
      if (ph_a != 2'd1) break;
    end
    chk("pause_resume", 32'(cnt), 32'd7);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
             ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 4)),
             $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
